// File: rtl/gate_bist_controller_if.sv
// Signal bundle between the gate-bank BIST controller and its environment.
// The master modport is the controller's view of the bundle.
interface gate_bist_controller_if;
  logic       start;
  logic       y_and;
  logic       y_or;
  logic       y_not;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [2:0] err_mask;
  logic [1:0] first_fail_vec;
  logic       first_fail_valid;

  modport master (
    input  start, y_and, y_or, y_not,
    output a, b, busy, done, pass, err_count, err_mask, first_fail_vec, first_fail_valid
  );

  modport slave (
    output start, y_and, y_or, y_not,
    input  a, b, busy, done, pass, err_count, err_mask, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_bist_controller.sv
// Built-in self-test sequencer for the AND/OR/NOT gate bank: walks a/b through
// all four vectors, checks each against golden values and reports the result.
module gate_bist_controller #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input logic                    clk,
  input logic                    rst,
  gate_bist_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settle_cnt;
  logic             a_q, b_q, busy_q, done_q, pass_q, ffv_q;
  logic [2:0]       err_count_q, err_mask_q;
  logic [1:0]       ffvec_q;
  logic [2:0]       mismatch;
  logic [1:0]       vec_next;

  // Bit order matches err_mask: {AND, OR, NOT}
  always_comb begin
    mismatch = {bus.y_and ^ (vec[1] & vec[0]),
                bus.y_or  ^ (vec[1] | vec[0]),
                bus.y_not ^ ~vec[1]};
    vec_next = vec + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vec         <= '0;
      settle_cnt  <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_mask_q  <= '0;
      ffvec_q     <= '0;
      ffv_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            vec         <= '0;
            settle_cnt  <= '0;
            err_count_q <= '0;
            err_mask_q  <= '0;
            ffvec_q     <= '0;
            ffv_q       <= 1'b0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch != 3'b000) begin
            if (err_count_q != 3'd4) err_count_q <= err_count_q + 3'd1;
            err_mask_q <= err_mask_q | mismatch;
            if (!ffv_q) begin
              ffvec_q <= vec;
              ffv_q   <= 1'b1;
            end
          end
          // a/b load with the next vector here so each new vector is on the pins
          // for the full settle window.
          if (vec == 2'd3) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            vec        <= vec_next;
            a_q        <= vec_next[1];
            b_q        <= vec_next[0];
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          pass_q <= (err_count_q == 3'd0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a                = a_q;
  assign bus.b                = b_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count_q;
  assign bus.err_mask         = err_mask_q;
  assign bus.first_fail_vec   = ffvec_q;
  assign bus.first_fail_valid = ffv_q;

endmodule
